// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-to-parallel receiver for the shift-register datapath.
//
// Frame format, in time order:
//   start bit (1), WIDTH data bits LSB first, optional even-parity bit, stop bit (0).
//
// The line is sampled only on edges where bit_en_i is high. Each good word is
// delivered into a one-entry holding register with a valid/ready handshake.
// A bad stop bit (or a bad parity, when enabled) produces a one-cycle frame_err_o
// pulse. A good word that arrives while the holding register is full and not
// being consumed is dropped and sets the sticky overrun_o flag.
//
// Build option: define SWR_PARITY_EN to add the even-parity bit after the data.
// The port list is the same in both builds.

module serial_word_receiver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             bit_en_i,
    input  logic             d_series_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o,
    input  logic             q_ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    // Explicit encodings keep the state width identical in both builds.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
`ifdef SWR_PARITY_EN
        StParity = 2'd2,
`endif
        StStop   = 2'd3
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;
`ifdef SWR_PARITY_EN
    // Running XOR of data bits and parity bit; zero at the stop bit means even parity holds.
    logic             par_q;
`endif

    logic stop_edge;
    logic word_ok;
    logic load_word;
    logic drop_word;

    // Decide at the stop edge whether the frame is good and where the word goes.
    always_comb begin
        stop_edge = bit_en_i && (state_q == StStop);
`ifdef SWR_PARITY_EN
        word_ok   = !d_series_i && !par_q;
`else
        word_ok   = !d_series_i;
`endif
        // A consumer handshake on the same edge frees the holding register for the new word.
        load_word = stop_edge && word_ok && (!q_valid_q || q_ready_i);
        drop_word = stop_edge && word_ok && q_valid_q && !q_ready_i;
    end

    // Frame FSM, shift register, holding register and status flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SWR_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;

            if (load_word) begin
                q_q       <= shift_q;
                q_valid_q <= 1'b1;
            end else if (q_valid_q && q_ready_i) begin
                q_valid_q <= 1'b0;
            end

            if (drop_word) begin
                overrun_q <= 1'b1;
            end

            if (bit_en_i) begin
                case (state_q)
                    StIdle: begin
                        if (d_series_i) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
`ifdef SWR_PARITY_EN
                            par_q   <= 1'b0;
`endif
                        end
                    end
                    StData: begin
                        // Shift right from the MSB end so the first data bit lands in bit 0.
                        shift_q <= {d_series_i, shift_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
`ifdef SWR_PARITY_EN
                        par_q   <= par_q ^ d_series_i;
                        if (cnt_q == LastBit) begin
                            state_q <= StParity;
                        end
`else
                        if (cnt_q == LastBit) begin
                            state_q <= StStop;
                        end
`endif
                    end
`ifdef SWR_PARITY_EN
                    StParity: begin
                        par_q   <= par_q ^ d_series_i;
                        state_q <= StStop;
                    end
`endif
                    StStop: begin
                        // A stop sample of 1 is never reused as the next start bit.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        if (!word_ok) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q_o         = q_q;
    assign q_valid_o   = q_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule
